// File: rtl/lfsr_pkg.sv
// lfsr_pkg: constants shared by the random-word buffer and its FIFO
package lfsr_pkg;
  localparam int DROP_CNT_W = 16;
  localparam int DEFAULT_DECIM = 32;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word fall-through FIFO with occupancy count and synchronous clear
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end
  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/lfsr_rand_buffer.sv
// lfsr_rand_buffer: decimates an LFSR word stream into a FIFO, counting samples dropped when full
module lfsr_rand_buffer
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int DECIM = WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             rand_in,
  input  logic                         enable,
  input  logic                         flush,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int LW = $clog2(DEPTH+1);
  logic [PW-1:0] phase;
  logic sample, pop, push;
  assign sample = enable && phase == PW'(DECIM-1);
  assign pop = rd_valid && rd_ready && !flush;
  // a full FIFO still accepts a sample when the head leaves in the same cycle
  assign push = sample && !flush && (level < LW'(DEPTH) || pop);
  assign rd_valid = level != '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      drop_cnt <= '0;
    end else begin
      phase <= (flush || !enable || sample) ? '0 : phase + PW'(1);
      drop_cnt <= flush ? '0 : (sample && !push && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
    end
  end
  sync_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .clear(flush),
    .push(push),
    .pop(pop),
    .wr_data(rand_in),
    .rd_data(rd_data),
    .level(level)
  );
endmodule

// File: tb/tb_lfsr_rand_buffer.sv
// tb_lfsr_rand_buffer: directed scoreboard bench for the decimating random-word buffer
module tb_lfsr_rand_buffer;
  logic clk = 0;
  logic reset_n = 0;
  logic enable = 0, flush = 0, rd_ready = 0;
  logic [31:0] rand_in;
  logic rd_valid;
  logic [31:0] rd_data;
  logic [2:0] level;
  logic [15:0] drop_cnt;
  logic s_rst_n = 0, s_enable = 0;
  logic s_valid;
  logic [7:0] s_data;
  logic [1:0] s_level;
  logic [15:0] s_drop;
  int cnt, scnt;
  int checks = 0, errors = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  lfsr_rand_buffer #(.WIDTH(32), .DEPTH(4), .DECIM(4)) dut (
    .clk(clk), .reset_n(reset_n), .rand_in(rand_in), .enable(enable), .flush(flush),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .drop_cnt(drop_cnt)
  );

  lfsr_rand_buffer #(.WIDTH(8), .DEPTH(2), .DECIM(1)) sat (
    .clk(clk), .reset_n(s_rst_n), .rand_in(scnt[7:0]), .enable(s_enable), .flush(1'b0),
    .rd_ready(1'b0), .rd_valid(s_valid), .rd_data(s_data), .level(s_level), .drop_cnt(s_drop)
  );

  always @(posedge clk or negedge reset_n) cnt <= !reset_n ? 0 : cnt + 1;
  always @(posedge clk or negedge s_rst_n) scnt <= !s_rst_n ? 0 : scnt + 1;
  assign rand_in = cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && !flush && rd_valid && rd_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0d expected none", rd_data);
      end else chk("pop_data", rd_data, q.pop_front());
    end
  end

  task automatic go(input int c);
    int b = 0;
    while (cnt != c) begin
      @(posedge clk);
      #1;
      if (++b > 2000) begin
        $display("FAIL go_timeout: got cycle %0d expected %0d", cnt, c);
        $fatal;
      end
    end
  endtask

  task automatic sgo(input int c);
    int b = 0;
    while (scnt != c) begin
      @(posedge clk);
      #1;
      if (++b > 90000) begin
        $display("FAIL sgo_timeout: got cycle %0d expected %0d", scnt, c);
        $fatal;
      end
    end
  endtask

  initial begin
    #2;
    chk("rst_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data", rd_data, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    enable = 1;
    s_rst_n = 1;
    s_enable = 1;
    q.push_back(3); q.push_back(7); q.push_back(11); q.push_back(15);
    go(16);
    chk("fill_level", level, 4);
    chk("fill_data", rd_data, 3);
    chk("fill_drop", drop_cnt, 0);
    go(20);
    chk("ovf_level", level, 4);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_data", rd_data, 3);
    go(23);
    rd_ready = 1;
    q.push_back(23);
    go(24);
    enable = 0;
    chk("pp_level", level, 4);
    chk("pp_drop", drop_cnt, 1);
    chk("pp_head", rd_data, 7);
    go(28);
    chk("drain_valid", rd_valid, 0);
    chk("drain_level", level, 0);
    chk("drain_queue", q.size(), 0);
    rd_ready = 0;
    enable = 1;
    q.push_back(31); q.push_back(35); q.push_back(39); q.push_back(43);
    go(48);
    chk("refill_level", level, 4);
    chk("refill_drop", drop_cnt, 2);
    chk("refill_data", rd_data, 31);
    go(51);
    flush = 1;
    go(52);
    flush = 0;
    q.delete();
    chk("flush_level", level, 0);
    chk("flush_valid", rd_valid, 0);
    chk("flush_drop", drop_cnt, 0);
    go(55);
    chk("post_flush_early", level, 0);
    q.push_back(55);
    go(56);
    chk("post_flush_level", level, 1);
    chk("post_flush_data", rd_data, 55);
    enable = 0;
    rd_ready = 1;
    go(57);
    chk("post_flush_drain", level, 0);
    chk("post_flush_queue", q.size(), 0);
    enable = 1;
    rd_ready = 0;
    go(69);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_data", rd_data, 60);
    #2;
    reset_n = 0;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_data", rd_data, 0);
    enable = 0;
    sgo(102);
    chk("sat_mid", s_drop, 100);
    sgo(65536);
    chk("sat_near", s_drop, 16'hFFFE);
    sgo(65537);
    chk("sat_top", s_drop, 16'hFFFF);
    sgo(65542);
    chk("sat_hold", s_drop, 16'hFFFF);
    chk("sat_level", s_level, 2);
    chk("sat_data", s_data, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
